// File: rtl/control_unit_if.sv
// Bundle between the hardwired control unit and DataPath: instruction/condition
// inputs from DataPath and every control strobe the unit drives back into it.
interface control_unit_if;
  logic [31:0] IR;
  logic        CON;
  logic        PCout, IncPC, MARin, PCin, MDRin, MDRout, IRin, Yin;
  logic        Gra, Grb, Grc, Rin, Rout, BAout, Cout;
  logic        read, write, RAMenable;
  logic        ZLOin, ZMuxEnable, ZMuxOut, ZSelect;
  logic        conin;
  logic [4:0]  aluControl;
  logic        run;

  modport master (
    input  IR, CON,
    output PCout, IncPC, MARin, PCin, MDRin, MDRout, IRin, Yin,
    output Gra, Grb, Grc, Rin, Rout, BAout, Cout,
    output read, write, RAMenable,
    output ZLOin, ZMuxEnable, ZMuxOut, ZSelect,
    output conin, aluControl, run
  );

  modport slave (
    output IR, CON,
    input  PCout, IncPC, MARin, PCin, MDRin, MDRout, IRin, Yin,
    input  Gra, Grb, Grc, Rin, Rout, BAout, Cout,
    input  read, write, RAMenable,
    input  ZLOin, ZMuxEnable, ZMuxOut, ZSelect,
    input  conin, aluControl, run
  );
endinterface

// File: rtl/control_unit.sv
// Hardwired control unit: steps each instruction through fetch T0-T2 and execute
// T3-T7 on the clock negedge, driving registered Moore strobes into DataPath.
module control_unit (
  input  logic           clock,
  input  logic           clear,
  control_unit_if.master bus
);

  typedef enum logic [3:0] {
    ST_RST, ST_T0, ST_T1, ST_T2, ST_T3, ST_T4, ST_T5, ST_T6, ST_T7, ST_HALT
  } state_t;

  typedef enum logic [2:0] {
    C_LD, C_LDI, C_ST, C_RFMT, C_IMM, C_BR, C_NOP, C_HALT
  } op_class_t;

  typedef struct packed {
    logic       pc_out, inc_pc, mar_in, pc_in, mdr_in, mdr_out, ir_in, y_in;
    logic       gra, grb, grc, r_in, r_out, ba_out, c_out;
    logic       rd, wr, ram_enable;
    logic       zlo_in, zmux_enable, zmux_out, zselect;
    logic       con_in;
    logic [4:0] alu;
    logic       run;
  } ctrl_t;

  function automatic op_class_t classify(input logic [4:0] op);
    op_class_t c;
    case (op)
      5'd0:                                       c = C_LD;
      5'd1:                                       c = C_LDI;
      5'd2:                                       c = C_ST;
      5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9,
      5'd10, 5'd11:                               c = C_RFMT;
      5'd12, 5'd13, 5'd14:                        c = C_IMM;
      5'd18:                                      c = C_BR;
      5'd27:                                      c = C_HALT;
      default:                                    c = C_NOP;
    endcase
    return c;
  endfunction

  function automatic logic [4:0] imm_alu(input logic [4:0] op);
    logic [4:0] a;
    case (op)
      5'd12:   a = 5'b00011;
      5'd13:   a = 5'b00101;
      5'd14:   a = 5'b00110;
      default: a = 5'b00000;
    endcase
    return a;
  endfunction

  state_t    state_r, next_state_s;
  ctrl_t     ctrl_r, next_ctrl_s;
  logic [4:0] opcode_s;
  op_class_t  class_s;

  assign opcode_s = bus.IR[31:27];
  assign class_s  = classify(opcode_s);

  // Next state, then the strobes of that next state so they register with it.
  always_comb begin
    next_state_s = state_r;
    next_ctrl_s  = '0;
    case (state_r)
      ST_RST:  next_state_s = ST_T0;
      ST_T0:   next_state_s = ST_T1;
      ST_T1:   next_state_s = ST_T2;
      ST_T2: begin
        case (class_s)
          C_HALT:  next_state_s = ST_HALT;
          C_NOP:   next_state_s = ST_T0;
          default: next_state_s = ST_T3;
        endcase
      end
      ST_T3:   next_state_s = ST_T4;
      ST_T4:   next_state_s = ST_T5;
      ST_T5: begin
        case (class_s)
          C_LD, C_ST, C_BR: next_state_s = ST_T6;
          default:          next_state_s = ST_T0;
        endcase
      end
      ST_T6: begin
        case (class_s)
          C_LD, C_ST: next_state_s = ST_T7;
          default:    next_state_s = ST_T0;
        endcase
      end
      ST_T7:   next_state_s = ST_T0;
      ST_HALT: next_state_s = ST_HALT;
      default: next_state_s = ST_RST;
    endcase

    next_ctrl_s.run = 1'b1;
    case (next_state_s)
      ST_RST, ST_HALT: next_ctrl_s.run = 1'b0;
      ST_T0: begin
        next_ctrl_s.pc_out = 1'b1;
        next_ctrl_s.mar_in = 1'b1;
        next_ctrl_s.inc_pc = 1'b1;
      end
      ST_T1: begin
        next_ctrl_s.rd         = 1'b1;
        next_ctrl_s.ram_enable = 1'b1;
        next_ctrl_s.mdr_in     = 1'b1;
      end
      ST_T2: begin
        next_ctrl_s.mdr_out = 1'b1;
        next_ctrl_s.ir_in   = 1'b1;
      end
      ST_T3: begin
        case (class_s)
          C_LD, C_LDI, C_ST: begin
            next_ctrl_s.grb    = 1'b1;
            next_ctrl_s.ba_out = 1'b1;
            next_ctrl_s.y_in   = 1'b1;
          end
          C_RFMT, C_IMM: begin
            next_ctrl_s.grb   = 1'b1;
            next_ctrl_s.r_out = 1'b1;
            next_ctrl_s.y_in  = 1'b1;
          end
          C_BR: begin
            next_ctrl_s.gra    = 1'b1;
            next_ctrl_s.r_out  = 1'b1;
            next_ctrl_s.con_in = 1'b1;
          end
          default: next_ctrl_s.run = 1'b1;
        endcase
      end
      ST_T4: begin
        case (class_s)
          C_LD, C_LDI, C_ST: begin
            next_ctrl_s.c_out  = 1'b1;
            next_ctrl_s.alu    = 5'b00011;
            next_ctrl_s.zlo_in = 1'b1;
          end
          C_RFMT: begin
            next_ctrl_s.grc    = 1'b1;
            next_ctrl_s.r_out  = 1'b1;
            next_ctrl_s.alu    = opcode_s;
            next_ctrl_s.zlo_in = 1'b1;
          end
          C_IMM: begin
            next_ctrl_s.c_out  = 1'b1;
            next_ctrl_s.alu    = imm_alu(opcode_s);
            next_ctrl_s.zlo_in = 1'b1;
          end
          C_BR: begin
            next_ctrl_s.pc_out = 1'b1;
            next_ctrl_s.y_in   = 1'b1;
          end
          default: next_ctrl_s.run = 1'b1;
        endcase
      end
      ST_T5: begin
        case (class_s)
          C_LD, C_ST: begin
            next_ctrl_s.zmux_enable = 1'b1;
            next_ctrl_s.zmux_out    = 1'b1;
            next_ctrl_s.mar_in      = 1'b1;
          end
          C_LDI, C_RFMT, C_IMM: begin
            next_ctrl_s.zmux_enable = 1'b1;
            next_ctrl_s.zmux_out    = 1'b1;
            next_ctrl_s.gra         = 1'b1;
            next_ctrl_s.r_in        = 1'b1;
          end
          C_BR: begin
            next_ctrl_s.c_out  = 1'b1;
            next_ctrl_s.alu    = 5'b00011;
            next_ctrl_s.zlo_in = 1'b1;
          end
          default: next_ctrl_s.run = 1'b1;
        endcase
      end
      ST_T6: begin
        case (class_s)
          C_LD: begin
            next_ctrl_s.rd         = 1'b1;
            next_ctrl_s.ram_enable = 1'b1;
            next_ctrl_s.mdr_in     = 1'b1;
          end
          C_ST: begin
            next_ctrl_s.gra    = 1'b1;
            next_ctrl_s.r_out  = 1'b1;
            next_ctrl_s.mdr_in = 1'b1;
          end
          C_BR: begin
            // CON was loaded in T3 and is stable here, so sampling it on entry to T6 is exact.
            next_ctrl_s.zmux_enable = 1'b1;
            next_ctrl_s.zmux_out    = 1'b1;
            next_ctrl_s.pc_in       = bus.CON;
          end
          default: next_ctrl_s.run = 1'b1;
        endcase
      end
      ST_T7: begin
        case (class_s)
          C_LD: begin
            next_ctrl_s.mdr_out = 1'b1;
            next_ctrl_s.gra     = 1'b1;
            next_ctrl_s.r_in    = 1'b1;
          end
          C_ST: begin
            next_ctrl_s.wr         = 1'b1;
            next_ctrl_s.ram_enable = 1'b1;
          end
          default: next_ctrl_s.run = 1'b1;
        endcase
      end
      default: next_ctrl_s.run = 1'b0;
    endcase
  end

  // State and strobe registers advance together on the negedge; clear zeroes both at once.
  always_ff @(negedge clock or negedge clear) begin
    if (!clear) begin
      state_r <= ST_RST;
      ctrl_r  <= '0;
    end else begin
      state_r <= next_state_s;
      ctrl_r  <= next_ctrl_s;
    end
  end

  assign bus.PCout      = ctrl_r.pc_out;
  assign bus.IncPC      = ctrl_r.inc_pc;
  assign bus.MARin      = ctrl_r.mar_in;
  assign bus.PCin       = ctrl_r.pc_in;
  assign bus.MDRin      = ctrl_r.mdr_in;
  assign bus.MDRout     = ctrl_r.mdr_out;
  assign bus.IRin       = ctrl_r.ir_in;
  assign bus.Yin        = ctrl_r.y_in;
  assign bus.Gra        = ctrl_r.gra;
  assign bus.Grb        = ctrl_r.grb;
  assign bus.Grc        = ctrl_r.grc;
  assign bus.Rin        = ctrl_r.r_in;
  assign bus.Rout       = ctrl_r.r_out;
  assign bus.BAout      = ctrl_r.ba_out;
  assign bus.Cout       = ctrl_r.c_out;
  assign bus.read       = ctrl_r.rd;
  assign bus.write      = ctrl_r.wr;
  assign bus.RAMenable  = ctrl_r.ram_enable;
  assign bus.ZLOin      = ctrl_r.zlo_in;
  assign bus.ZMuxEnable = ctrl_r.zmux_enable;
  assign bus.ZMuxOut    = ctrl_r.zmux_out;
  assign bus.ZSelect    = ctrl_r.zselect;
  assign bus.conin      = ctrl_r.con_in;
  assign bus.aluControl = ctrl_r.alu;
  assign bus.run        = ctrl_r.run;

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: an instruction-level model queues the expected
// strobe word for every cycle; a posedge monitor pops and compares.
module tb_control_unit;
  logic clock = 1'b0;
  logic clear = 1'b0;

  control_unit_if bus ();
  control_unit dut (.clock(clock), .clear(clear), .bus(bus));

  always #5 clock = ~clock;

  localparam logic [28:0] PCOUT  = 29'd1 << 28;
  localparam logic [28:0] INCPC  = 29'd1 << 27;
  localparam logic [28:0] MARIN  = 29'd1 << 26;
  localparam logic [28:0] PCIN   = 29'd1 << 25;
  localparam logic [28:0] MDRIN  = 29'd1 << 24;
  localparam logic [28:0] MDROUT = 29'd1 << 23;
  localparam logic [28:0] IRIN   = 29'd1 << 22;
  localparam logic [28:0] YIN    = 29'd1 << 21;
  localparam logic [28:0] GRA    = 29'd1 << 20;
  localparam logic [28:0] GRB    = 29'd1 << 19;
  localparam logic [28:0] GRC    = 29'd1 << 18;
  localparam logic [28:0] RIN    = 29'd1 << 17;
  localparam logic [28:0] ROUT   = 29'd1 << 16;
  localparam logic [28:0] BAOUT  = 29'd1 << 15;
  localparam logic [28:0] COUT   = 29'd1 << 14;
  localparam logic [28:0] RD     = 29'd1 << 13;
  localparam logic [28:0] WR     = 29'd1 << 12;
  localparam logic [28:0] RAM    = 29'd1 << 11;
  localparam logic [28:0] ZLO    = 29'd1 << 10;
  localparam logic [28:0] ZMEN   = 29'd1 << 9;
  localparam logic [28:0] ZMOUT  = 29'd1 << 8;
  localparam logic [28:0] CONIN  = 29'd1 << 6;
  localparam logic [28:0] RUN    = 29'd1;
  localparam logic [28:0] ZOUT   = ZMEN | ZMOUT;

  typedef struct {
    logic [28:0] vec;
    string       tag;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  function automatic logic [28:0] act_vec();
    return {bus.PCout, bus.IncPC, bus.MARin, bus.PCin, bus.MDRin, bus.MDRout, bus.IRin,
            bus.Yin, bus.Gra, bus.Grb, bus.Grc, bus.Rin, bus.Rout, bus.BAout, bus.Cout,
            bus.read, bus.write, bus.RAMenable, bus.ZLOin, bus.ZMuxEnable, bus.ZMuxOut,
            bus.ZSelect, bus.conin, bus.aluControl, bus.run};
  endfunction

  function automatic logic [28:0] alu(input logic [4:0] a);
    return {23'd0, a, 1'b0};
  endfunction

  function automatic void expect_step(input logic [28:0] v, input string t);
    exp_t e;
    e.vec = v;
    e.tag = t;
    exp_q.push_back(e);
  endfunction

  // Instruction-level model: queue every cycle of one instruction, return its length.
  function automatic int push_instr(input logic [4:0] op, input logic con, input string nm);
    logic [28:0] s[$];
    s.push_back(PCOUT | MARIN | INCPC);
    s.push_back(RD | RAM | MDRIN);
    s.push_back(MDROUT | IRIN);
    if (op == 5'd0) begin
      s.push_back(GRB | BAOUT | YIN);
      s.push_back(COUT | alu(5'd3) | ZLO);
      s.push_back(ZOUT | MARIN);
      s.push_back(RD | RAM | MDRIN);
      s.push_back(MDROUT | GRA | RIN);
    end else if (op == 5'd1) begin
      s.push_back(GRB | BAOUT | YIN);
      s.push_back(COUT | alu(5'd3) | ZLO);
      s.push_back(ZOUT | GRA | RIN);
    end else if (op == 5'd2) begin
      s.push_back(GRB | BAOUT | YIN);
      s.push_back(COUT | alu(5'd3) | ZLO);
      s.push_back(ZOUT | MARIN);
      s.push_back(GRA | ROUT | MDRIN);
      s.push_back(WR | RAM);
    end else if (op >= 5'd3 && op <= 5'd11) begin
      s.push_back(GRB | ROUT | YIN);
      s.push_back(GRC | ROUT | alu(op) | ZLO);
      s.push_back(ZOUT | GRA | RIN);
    end else if (op >= 5'd12 && op <= 5'd14) begin
      s.push_back(GRB | ROUT | YIN);
      s.push_back(COUT | ZLO | alu(op == 5'd12 ? 5'd3 : (op == 5'd13 ? 5'd5 : 5'd6)));
      s.push_back(ZOUT | GRA | RIN);
    end else if (op == 5'd18) begin
      s.push_back(GRA | ROUT | CONIN);
      s.push_back(PCOUT | YIN);
      s.push_back(COUT | alu(5'd3) | ZLO);
      s.push_back(ZOUT | (con ? PCIN : 29'd0));
    end
    for (int i = 0; i < s.size(); i++)
      expect_step(s[i] | RUN, $sformatf("%s_T%0d", nm, i));
    return s.size();
  endfunction

  // Monitor: compare the DUT strobe word with the scoreboard at every posedge.
  always @(posedge clock) begin : monitor
    exp_t        e;
    logic [28:0] a;
    a = act_vec();
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      checks++;
      if (a !== e.vec) begin
        failures++;
        $display("FAIL %s actual=%h required=%h", e.tag, a, e.vec);
      end
    end else if (bus.run !== 1'b0) begin
      checks++;
      failures++;
      $display("FAIL unexpected_activity actual_run=%b required_run=0", bus.run);
    end
  end

  // Called just after a posedge: assert clear mid-cycle, hold, then release into T0.
  task automatic do_reset(input string nm, input int cycles);
    #2;
    clear = 1'b0;
    #1;
    checks++;
    if (act_vec() !== 29'd0) begin
      failures++;
      $display("FAIL %s_immediate actual=%h required=%h", nm, act_vec(), 29'd0);
    end
    for (int i = 0; i < cycles; i++) expect_step(29'd0, $sformatf("%s_hold%0d", nm, i));
    repeat (cycles) @(posedge clock);
    #1;
    clear = 1'b1;
    @(negedge clock);
    #1;
  endtask

  task automatic do_halt(input logic [31:0] ir, input string nm);
    int n;
    bus.IR = ir;
    n = push_instr(5'd27, 1'b0, nm);
    repeat (n) @(negedge clock);
    #1;
    for (int i = 0; i < 4; i++) expect_step(29'd0, $sformatf("%s_halted%0d", nm, i));
    repeat (4) @(posedge clock);
  endtask

  // Entered just after the negedge into T0; leaves just after the next T0 entry.
  task automatic run_instr(input logic [31:0] ir, input logic con, input string nm);
    int n;
    bus.IR  = ir;
    bus.CON = con;
    if (ir[31:27] == 5'd27) begin
      do_halt(ir, nm);
      do_reset({nm, "_clr"}, 2);
    end else begin
      n = push_instr(ir[31:27], con, nm);
      repeat (n) @(negedge clock);
      #1;
    end
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    logic [31:0] r;
    logic [4:0]  op;
    bus.IR  = 32'd0;
    bus.CON = 1'b0;
    #1;
    checks++;
    if (act_vec() !== 29'd0) begin
      failures++;
      $display("FAIL reset_state actual=%h required=%h", act_vec(), 29'd0);
    end
    expect_step(29'd0, "reset_hold0");
    expect_step(29'd0, "reset_hold1");
    repeat (2) @(posedge clock);
    #1;
    clear = 1'b1;
    @(negedge clock);
    #1;

    run_instr(32'h08800064, 1'b0, "ldi");
    r = $urandom(); run_instr({5'd2, r[26:0]}, 1'b0, "st");
    r = $urandom(); run_instr({5'd0, r[26:0]}, 1'b0, "ld");
    r = $urandom(); run_instr({5'd4, r[26:0]}, 1'b0, "sub");
    r = $urandom(); run_instr({5'd18, r[26:0]}, 1'b1, "br_taken");
    r = $urandom(); run_instr({5'd18, r[26:0]}, 1'b0, "br_not");
    r = $urandom(); run_instr({5'd26, r[26:0]}, 1'b0, "nop");
    r = $urandom(); run_instr({5'd13, r[26:0]}, 1'b0, "andi");
    r = $urandom(); run_instr({5'd27, r[26:0]}, 1'b0, "halt");

    // Mid-instruction clear during ld T6: no T7, straight back to reset.
    r = $urandom();
    bus.IR = {5'd0, r[26:0]};
    void'(push_instr(5'd0, 1'b0, "ld_mid"));
    repeat (6) @(negedge clock);
    @(posedge clock);
    #1;
    void'(exp_q.pop_back());
    do_reset("midop_ld", 2);

    for (int k = 0; k < 40; k++) begin
      r  = $urandom();
      op = 5'($urandom_range(0, 31));
      run_instr({op, r[26:0]}, 1'($urandom_range(0, 1)), $sformatf("rnd%0d_op%0d", k, op));
    end

    r = $urandom();
    do_halt({5'd27, r[26:0]}, "final_halt");
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clock);
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain actual=%0d required=0", exp_q.size());
    end
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/control_unit.md
# control_unit

Hardwired control unit for the RISC CPU. It sequences every instruction through fetch (T0–T2) and execute (T3–T7) steps. In each step it drives the DataPath control inputs (PCout, MARin, Gra/Grb/Grc, Rin/Rout, BAout, Cout, Z-mux, memory strobes, aluControl) from the opcode held in IR. It sits beside DataPath and replaces hand-sequenced control stimulus: the CPU top level is control_unit plus DataPath.

## Interface
Parameters:
- none

Ports:
- clock  in  1  system clock
- clear  in  1  asynchronous, active-low reset
- IR  in  32  instruction register contents from DataPath; opcode = IR[31:27]
- CON  in  1  branch condition flip-flop output from DataPath
- PCout, IncPC, MARin, PCin, MDRin, MDRout, IRin, Yin  out  1 each  DataPath register/bus strobes
- Gra, Grb, Grc, Rin, Rout, BAout, Cout  out  1 each  register-select and operand strobes
- read, write, RAMenable  out  1 each  memory strobes
- ZLOin, ZMuxEnable, ZMuxOut, ZSelect  out  1 each  Z register capture and bus-out (ZSelect=0 selects the low word)
- conin  out  1  load CON flip-flop
- aluControl  out  5  ALU operation
- run  out  1  high while executing; low after halt

## Operation
- State register advances on the **negedge** of clock. Outputs are a pure Moore decode of state, so every strobe is stable for the full cycle around the DataPath posedge capture.
- States: RST, T0, T1, T2, T3, T4, T5, T6, T7, HALT.
- Fetch, identical for all opcodes:
  - T0: PCout, MARin, IncPC.
  - T1: read, RAMenable, MDRin.
  - T2: MDRout, IRin.
- "Zout" in the steps below means ZMuxEnable=1, ZMuxOut=1, ZSelect=0.
- Execute, decoded from IR[31:27] in T3 and later:
  - ld 00000:
    - T3 Grb, BAout, Yin.
    - T4 Cout, aluControl=00011, ZLOin.
    - T5 Zout, MARin.
    - T6 read, RAMenable, MDRin.
    - T7 MDRout, Gra, Rin.
  - ldi 00001:
    - T3 Grb, BAout, Yin.
    - T4 Cout, aluControl=00011, ZLOin.
    - T5 Zout, Gra, Rin.
  - st 00010:
    - T3 Grb, BAout, Yin.
    - T4 Cout, aluControl=00011, ZLOin.
    - T5 Zout, MARin.
    - T6 Gra, Rout, MDRin.
    - T7 write, RAMenable.
  - R-format 00011–01011:
    - T3 Grb, Rout, Yin.
    - T4 Grc, Rout, aluControl=IR[31:27], ZLOin.
    - T5 Zout, Gra, Rin.
  - addi 01100 / andi 01101 / ori 01110:
    - T3 Grb, Rout, Yin.
    - T4 Cout, ZLOin, aluControl=00011 / 00101 / 00110 respectively.
    - T5 Zout, Gra, Rin.
  - br 10010:
    - T3 Gra, Rout, conin.
    - T4 PCout, Yin.
    - T5 Cout, aluControl=00011, ZLOin.
    - T6 Zout, and PCin only if CON=1 (CON sampled in T6).
  - nop 11010: T2 → T0.
  - halt 11011: T2 → HALT.
  - Any other opcode: treated as nop.
- Last execute step → T0. Step counts: ld/st end at T7, br at T6, ldi/R/imm at T5.
- aluControl is 00000 in every state not listed above.

## Timing
- Reset (clear=0, asynchronous):
  - State = RST.
  - All 1-bit outputs = 0, aluControl = 00000, run = 0.
- First negedge with clear=1: RST → T0, run = 1.
- Instruction latency in cycles:
  - ld/st: 8.
  - br: 7.
  - ldi/R-format/imm: 6.
  - nop: 3.
- HALT is absorbing: all strobes 0, run = 0. Only clear exits it.
- clear asserted mid-instruction (any state): immediate return to RST with all outputs 0. No partial memory write completes after assertion.
- Exactly one state is active per cycle. Gra, Grb and Grc are never asserted together. Rin and Rout are never asserted together. read and write are never asserted together.

## Test plan
- Reset/start:
  - Stimulus: clear=0 for 2 cycles, then release.
  - Response: all outputs 0 and run=0 while clear=0; at the first negedge after release, PCout=MARin=IncPC=1.
- ldi:
  - Stimulus: IR=0x08800064 (ldi R1, 0x64(R0)).
  - Response, one line per cycle:
    - T3: Grb, BAout, Yin.
    - T4: Cout, aluControl=00011, ZLOin.
    - T5: ZMuxEnable, ZMuxOut, Gra, Rin, with ZSelect=0.
    - Next cycle: T0.
- st then ld:
  - Stimulus: IR opcodes 00010, then 00000.
  - Response: write+RAMenable only in st T7; read+RAMenable+MDRin in ld T6; MDRout+Gra+Rin in ld T7. 8 cycles per instruction.
- R-format sub:
  - Stimulus: IR[31:27]=00100.
  - Response: aluControl=00100 only in T4; Grc+Rout in T4.
- br taken/not taken:
  - Stimulus: opcode 10010 with CON=1, then CON=0.
  - Response: PCin=1 in T6 only when CON=1; conin=1 in T3 in both cases.
- halt and mid-op reset:
  - Stimulus: opcode 11011; separately, clear=0 during ld T6.
  - Response: halt gives run=0 with all strobes 0 until clear; the mid-op reset forces all outputs to 0 immediately, with no write and no T7.
